fb_div_sched: RTL and testbench



---
 rtl/fb_div_sched.sv | 120 ++++++++++++
 tb/tb_fb_div_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_div_sched.sv
// Feedback-divider scheduler: divides clk by 2*cur_half to produce clk_d.
// A new half-period is accepted over a valid/ready handshake, held pending,
// and applied only on the 1->0 transition of clk_d so no runt or stretched
// pulse ever reaches the phase detector.
module fb_div_sched #(
   parameter int CW           = 8,
   parameter int DEFAULT_HALF = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          cfg_valid,
   input  logic [CW-1:0] cfg_half,
   output logic          cfg_ready,
   output logic          clk_d,
   output logic          tog,
   output logic          upd_done,
   output logic [CW-1:0] cur_half,
   output logic          err
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [CW-1:0] HALF_RST = CW'(DEFAULT_HALF);
   localparam logic [CW-1:0] ONE      = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [CW-1:0] half_q,  half_d;
   logic [CW-1:0] pend_q,  pend_d;
   logic          clk_d_q, clk_d_d;
   logic          tog_q,   tog_d;
   logic          upd_q,   upd_d;
   logic          err_q,   err_d;

   logic          terminal;
   logic          boundary;

   // Last enabled count of a phase; the falling-edge variant is the only apply point.
   assign terminal = en && (cnt_q == (half_q - ONE));
   assign boundary = terminal && clk_d_q;

   // State register; reset wins over every input, dropping any pending value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         half_q  <= HALF_RST;
         pend_q  <= '0;
         clk_d_q <= 1'b0;
         tog_q   <= 1'b0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         pend_q  <= pend_d;
         clk_d_q <= clk_d_d;
         tog_q   <= tog_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: phase counter plus the IDLE/PEND handshake FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      pend_d  = pend_q;
      clk_d_d = clk_d_q;
      tog_d   = 1'b0;
      upd_d   = 1'b0;
      err_d   = err_q;

      if (en) begin
         if (terminal) begin
            cnt_d   = '0;
            clk_d_d = ~clk_d_q;
            tog_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end

      case (state_q)
         IDLE: begin
            // A value taken on a boundary edge waits for the next fall.
            if (cfg_valid) begin
               if (cfg_half != '0) begin
                  pend_d  = cfg_half;
                  state_d = PEND;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         PEND: begin
            if (boundary) begin
               half_d  = pend_q;
               upd_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cfg_ready = (state_q == IDLE);
   assign clk_d     = clk_d_q;
   assign tog       = tog_q;
   assign upd_done  = upd_q;
   assign cur_half  = half_q;
   assign err       = err_q;

endmodule

// File: tb/tb_fb_div_sched.sv
// Directed bench for fb_div_sched: cycle-by-cycle vector table for reset,
// ratio update, zero/back-pressure, plus sequences for divide-by-2, enable
// hold and reset while a value is pending.
module tb_fb_div_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       cfg_valid;
   logic [7:0] cfg_half;
   logic       cfg_ready;
   logic       clk_d;
   logic       tog;
   logic       upd_done;
   logic [7:0] cur_half;
   logic       err;

   int checks   = 0;
   int failures = 0;

   fb_div_sched #(.CW(8), .DEFAULT_HALF(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_half  (cfg_half),
      .cfg_ready (cfg_ready),
      .clk_d     (clk_d),
      .tog       (tog),
      .upd_done  (upd_done),
      .cur_half  (cur_half),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, vld;
      logic [7:0] half;
      logic       e_clk, e_tog, e_upd;
      logic [7:0] e_half;
      logic       e_rdy, e_err;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int r, e, v, h, ec, et, eu, eh, er, ee);
      vec_t t;
      t.rst = r[0]; t.en = e[0]; t.vld = v[0]; t.half = h[7:0];
      t.e_clk = ec[0]; t.e_tog = et[0]; t.e_upd = eu[0];
      t.e_half = eh[7:0]; t.e_rdy = er[0]; t.e_err = ee[0];
      vq.push_back(t);
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int ups;
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;

      // rst en vld half | clk tog upd half rdy err   (outputs after the edge)
      add(1,0,0,0, 0,0,0,4,1,0);
      add(1,1,1,5, 0,0,0,4,1,0);                                  // reset beats handshake
      for (int i = 0; i < 3; i++) add(0,1,0,0, 0,0,0,4,1,0);      // edges 1..3
      add(0,1,0,0, 1,1,0,4,1,0);                                  // edge 4 rise
      for (int i = 0; i < 3; i++) add(0,1,0,0, 1,0,0,4,1,0);
      add(0,1,0,0, 0,1,0,4,1,0);                                  // edge 8 fall
      for (int i = 0; i < 3; i++) add(0,1,0,0, 0,0,0,4,1,0);
      add(0,1,0,0, 1,1,0,4,1,0);                                  // edge 12 rise
      add(0,1,0,0, 1,0,0,4,1,0);
      add(0,1,1,6, 1,0,0,4,0,0);                                  // edge 14: take 6
      add(0,1,0,0, 1,0,0,4,0,0);
      add(0,1,0,0, 0,1,1,6,1,0);                                  // edge 16: apply
      for (int i = 0; i < 5; i++) add(0,1,0,0, 0,0,0,6,1,0);
      add(0,1,0,0, 1,1,0,6,1,0);                                  // edge 22: 6 low done
      for (int i = 0; i < 5; i++) add(0,1,0,0, 1,0,0,6,1,0);
      add(0,1,0,0, 0,1,0,6,1,0);                                  // edge 28: 6 high done
      add(0,1,1,0, 0,0,0,6,1,1);                                  // zero -> err, stay IDLE
      add(0,1,1,3, 0,0,0,6,0,1);                                  // take 3
      for (int i = 0; i < 3; i++) add(0,1,1,9, 0,0,0,6,0,1);      // 9 held, not taken
      add(0,1,1,9, 1,1,0,6,0,1);                                  // edge 34 rise, no apply
      for (int i = 0; i < 5; i++) add(0,1,1,9, 1,0,0,6,0,1);
      add(0,1,1,9, 0,1,1,3,1,1);                                  // edge 40 apply 3
      add(0,1,1,9, 0,0,0,3,0,1);                                  // 9 taken
      add(0,1,0,0, 0,0,0,3,0,1);
      add(0,1,0,0, 1,1,0,3,0,1);
      for (int i = 0; i < 2; i++) add(0,1,0,0, 1,0,0,3,0,1);
      add(0,1,0,0, 0,1,1,9,1,1);                                  // edge 46 apply 9
      add(0,1,0,0, 0,0,0,9,1,1);

      foreach (vq[i]) begin
         rst = vq[i].rst; en = vq[i].en; cfg_valid = vq[i].vld; cfg_half = vq[i].half;
         tick();
         chk1($sformatf("vec%0d clk_d", i),     clk_d,     vq[i].e_clk);
         chk1($sformatf("vec%0d tog", i),       tog,       vq[i].e_tog);
         chk1($sformatf("vec%0d upd_done", i),  upd_done,  vq[i].e_upd);
         chk8($sformatf("vec%0d cur_half", i),  cur_half,  vq[i].e_half);
         chk1($sformatf("vec%0d cfg_ready", i), cfg_ready, vq[i].e_rdy);
         chk1($sformatf("vec%0d err", i),       err,       vq[i].e_err);
      end

      // Divide-by-2: request 1 on the first edge, applied at the edge-8 fall.
      do_reset();
      en = 1'b1; cfg_valid = 1'b1; cfg_half = 8'd1;
      tick();
      chk1("div2 ready low", cfg_ready, 1'b0);
      cfg_valid = 1'b0; cfg_half = 8'd0;
      n = 1;
      while (!upd_done && n < 40) begin
         tick();
         n++;
      end
      chkn("div2 apply edge", n, 8);
      chk8("div2 cur_half", cur_half, 8'd1);
      chk1("div2 clk_d at apply", clk_d, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk1($sformatf("div2 clk_d %0d", i), clk_d, (i % 2) == 0);
         chk1($sformatf("div2 tog %0d", i), tog, 1'b1);
      end

      // Enable hold: freeze 5 cycles two counts into the first high phase.
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk1("hold rise clk_d", clk_d, 1'b1);
      chk1("hold rise tog", tog, 1'b1);
      tick();
      tick();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1($sformatf("hold clk_d %0d", i), clk_d, 1'b1);
         chk1($sformatf("hold tog %0d", i), tog, 1'b0);
         chk8($sformatf("hold cnt %0d", i), dut.cnt_q, 8'd2);
      end
      en = 1'b1;
      tick();
      chk1("hold resume clk_d", clk_d, 1'b1);
      chk1("hold resume tog", tog, 1'b0);
      tick();
      chk1("hold fall clk_d", clk_d, 1'b0);
      chk1("hold fall tog", tog, 1'b1);

      // Reset while PEND: the pending 7 must vanish.
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      cfg_valid = 1'b1; cfg_half = 8'd7;
      tick();
      chk1("rstpend ready low", cfg_ready, 1'b0);
      cfg_valid = 1'b0; cfg_half = 8'd0; rst = 1'b1;
      tick();
      chk1("rstpend clk_d", clk_d, 1'b0);
      chk1("rstpend tog", tog, 1'b0);
      chk1("rstpend upd", upd_done, 1'b0);
      chk8("rstpend cur_half", cur_half, 8'd4);
      chk1("rstpend ready", cfg_ready, 1'b1);
      chk1("rstpend err", err, 1'b0);
      rst = 1'b0;
      ups = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (upd_done) ups++;
         chk1($sformatf("rstpend clk_d e%0d", e), clk_d, ((e / 4) % 2) == 1);
      end
      chkn("rstpend upd pulses", ups, 0);
      chk8("rstpend cur_half end", cur_half, 8'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
